// File: rtl/hex4_scan_driver.sv
// Multiplexed driver for a 4-digit common-anode 7-segment display with double-buffered value.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module hex4_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   stage_val, shadow_val;
  logic [3:0]    stage_dp, shadow_dp;
  logic          pending;
  logic          tc, fb;
  logic [3:0]    nib;
  logic [3:0]    blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  assign tc  = (cnt == CW'(REFRESH_DIV - 1));
  assign fb  = tc && (idx == 2'd3);
  assign nib = shadow_val[{idx, 2'b00} +: 4];

  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only while it and everything to its left is zero with no dp.
    blank[3] = (shadow_val[15:12] == 4'h0) && !shadow_dp[3];
    blank[2] = blank[3] && (shadow_val[11:8] == 4'h0) && !shadow_dp[2];
    blank[1] = blank[2] && (shadow_val[7:4]  == 4'h0) && !shadow_dp[1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      stage_val  <= '0;
      stage_dp   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      digit_sel  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      if (tc) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Shadow only changes at the frame boundary; a load in that cycle bypasses staging.
      if (fb) begin
        if (load) begin
          shadow_val <= value;
          shadow_dp  <= dp_in;
        end else if (pending) begin
          shadow_val <= stage_val;
          shadow_dp  <= stage_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        stage_val <= value;
        stage_dp  <= dp_in;
        pending   <= 1'b1;
      end

      frame_done <= fb;
      digit_sel  <= idx;
      if (blank[idx]) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= hex_seg(nib);
        dp  <= ~shadow_dp[idx];
      end
    end
  end
endmodule

// File: tb/tb_hex4_scan_driver.sv
// Scoreboard bench for hex4_scan_driver: driver pushes the expected post-edge outputs from a
// cycle-count model, monitor pops and compares after every rising edge.
module tb_hex4_scan_driver;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  hex4_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 0;
  bit   done = 0;

  // Model: k = number of non-reset clock edges since the last reset edge.
  int          k = 0;
  logic [15:0] sh_v = '0, st_v = '0;
  logic [3:0]  sh_d = '0, st_d = '0;
  bit          pend = 0;

  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic exp_t reset_exp();
    exp_t e;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.sel = 2'd0; e.fd = 1'b0;
    return e;
  endfunction

  function automatic exp_t model_exp(int kk, logic [15:0] v, logic [3:0] d);
    exp_t e;
    int   dig;
    bit   blank;
    dig   = (kk / DIV) % 4;
    blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (dig != 0) && ((v >> (4 * dig)) == 16'h0) && ((d >> dig) == 4'h0);
`endif
    e.sel = 2'(dig);
    e.fd  = ((kk % FRAME) == FRAME - 1);
    if (blank) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    end else begin
      e.an  = 4'hF ^ 4'(1 << dig);
      e.seg = segtab[(v >> (4 * dig)) & 16'hF];
      e.dp  = !d[dig];
    end
    return e;
  endfunction

  task automatic cyc(input bit r, input bit l, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    rst = r; load = l; value = v; dp_in = d;
    started = 1;
    if (r) begin
      q.push_back(reset_exp());
      k = 0; sh_v = '0; sh_d = '0; st_v = '0; st_d = '0; pend = 0;
    end else begin
      q.push_back(model_exp(k, sh_v, sh_d));
      if ((k % FRAME) == FRAME - 1) begin
        if (l) begin sh_v = v; sh_d = d; end
        else if (pend) begin sh_v = st_v; sh_d = st_d; end
        pend = 0;
      end else if (l) begin
        st_v = v; st_d = d; pend = 1;
      end
      k++;
    end
  endtask

  task automatic idle_to(input int target);
    while (k < target) cyc(0, 0, 16'($urandom), 4'($urandom));
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started && !done) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 0, 1);
        end else begin
          e = q.pop_front();
          chk("an", an, e.an);
          chk("seg", seg, e.seg);
          chk("dp", dp, e.dp);
          chk("digit_sel", digit_sel, e.sel);
          chk("frame_done", frame_done, e.fd);
        end
      end
    end
  end

  initial begin : driver
    repeat (3) cyc(1, 0, 16'h0, 4'h0);
    idle_to(FRAME + 4);                    // through frame 0, into frame 1 digit 1
    cyc(0, 1, 16'hF1E2, 4'h0);             // mid-frame load
    idle_to(3 * FRAME);
    cyc(0, 1, 16'h1234, 4'h0);             // two loads in one frame
    idle_to(3 * FRAME + 4);
    cyc(0, 1, 16'hD3C4, 4'h0);
    idle_to(5 * FRAME - 1);
    cyc(0, 1, 16'h00B5, 4'b0100);          // load in the frame-boundary cycle
    idle_to(5 * FRAME + 5);
    cyc(0, 1, 16'hABCD, 4'h0);
    idle_to(6 * FRAME + 9);                // digit 2 slot showing ABCD
    cyc(1, 0, 16'h0, 4'h0);
    cyc(1, 0, 16'h0, 4'h0);
    idle_to(FRAME + 2);
    cyc(0, 1, 16'h0042, 4'h0);
    idle_to(3 * FRAME);
    cyc(0, 1, 16'h0000, 4'h0);
    idle_to(5 * FRAME);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), v,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end
    @(negedge clk);
    done = 1;
    if (q.size() != 0) chk("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
